conv_sequencer: RTL and testbench

Sequences one convolution layer through the 4-lane MAC/accumulator datapath. It walks the output loop nest (m, r, c) and the reduction loop nest (n-word, i, j), and generates read addresses and enables for the input and weight buffers. It aligns accumulator enable and clear to the datapath pipeline, then issues one packed output-buffer write per finished neuron. It replaces the free-running loop counter plus controller pair, with a start/done handshake.

---
 rtl/conv_pkg.sv | 51 +++++
 rtl/conv_sequencer_if.sv | 35 +++
 rtl/conv_loop_ctr.sv | 51 +++++
 rtl/conv_sequencer.sv | 179 +++++++++++++++++
 tb/tb_conv_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution layer sequencer.
package conv_pkg;

  localparam int unsigned DefAw      = 16;
  localparam int unsigned DefCw      = 8;
  localparam int unsigned DefPipeLat = 2;

  // Tag address is carried at a fixed width; the parent supports AW up to this.
  localparam int unsigned TagAddrW = 32;

  // Loop-nest level indices, innermost first.
  localparam int unsigned NumLevels = 6;
  localparam int unsigned LvlJ  = 0;
  localparam int unsigned LvlI  = 1;
  localparam int unsigned LvlNw = 2;
  localparam int unsigned LvlC  = 3;
  localparam int unsigned LvlR  = 4;
  localparam int unsigned LvlM  = 5;

  localparam logic [7:0] LaneMask0 = 8'hC0;
  localparam logic [7:0] LaneMask1 = 8'h30;
  localparam logic [7:0] LaneMask2 = 8'h0C;
  localparam logic [7:0] LaneMask3 = 8'h03;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } conv_state_e;

  typedef struct packed {
    logic                valid;
    logic                first;
    logic                last;
    logic [TagAddrW-1:0] addr;
    logic [1:0]          lane;
  } conv_tag_t;

  function automatic logic [7:0] lane_mask(input logic [1:0] lane);
    logic [7:0] mask;
    unique case (lane)
      2'd0:    mask = LaneMask0;
      2'd1:    mask = LaneMask1;
      2'd2:    mask = LaneMask2;
      default: mask = LaneMask3;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Control handshake, layer config and buffer-port bundle of the conv sequencer.
interface conv_sequencer_if #(
  parameter int unsigned AW = conv_pkg::DefAw,
  parameter int unsigned CW = conv_pkg::DefCw
);
  logic          start;
  logic [CW-1:0] cfg_m;
  logic [CW-1:0] cfg_r;
  logic [CW-1:0] cfg_c;
  logic [CW-1:0] cfg_nw;
  logic [3:0]    cfg_k;
  logic          busy;
  logic          done;
  logic          ifm_en;
  logic [AW-1:0] ifm_addr;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic          acc_en;
  logic          acc_clear;
  logic          out_en;
  logic [7:0]    out_we;
  logic [AW-1:0] out_addr;

  modport master (
    output start, cfg_m, cfg_r, cfg_c, cfg_nw, cfg_k,
    input  busy, done, ifm_en, ifm_addr, w_en, w_addr, acc_en, acc_clear,
    input  out_en, out_we, out_addr
  );

  modport slave (
    input  start, cfg_m, cfg_r, cfg_c, cfg_nw, cfg_k,
    output busy, done, ifm_en, ifm_addr, w_en, w_addr, acc_en, acc_clear,
    output out_en, out_we, out_addr
  );
endinterface

// File: rtl/conv_loop_ctr.sv
// Nested multi-level counter; level 0 is innermost and advances on adv_i.
module conv_loop_ctr #(
  parameter int unsigned Levels = 6,
  parameter int unsigned W      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic                      adv_i,
  input  logic [Levels-1:0][W-1:0]  lim_i,
  output logic [Levels-1:0][W-1:0]  cnt_o,
  output logic [Levels-1:0]         lvl_last_o
);

  logic [Levels-1:0][W-1:0] cnt_q, cnt_d;
  logic [Levels-1:0]        lvl_last;
  logic [Levels-1:0]        carry;

  always_comb begin
    lvl_last = '0;
    for (int unsigned l = 0; l < Levels; l++) begin
      lvl_last[l] = (cnt_q[l] == lim_i[l] - W'(1));
    end
    // A level steps when every inner level is at its limit.
    carry    = '0;
    carry[0] = adv_i;
    for (int unsigned l = 1; l < Levels; l++) begin
      carry[l] = carry[l-1] & lvl_last[l-1];
    end
    cnt_d = cnt_q;
    for (int unsigned l = 0; l < Levels; l++) begin
      if (clr_i) begin
        cnt_d[l] = '0;
      end else if (carry[l]) begin
        cnt_d[l] = lvl_last[l] ? '0 : cnt_q[l] + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign lvl_last_o = lvl_last;

endmodule

// File: rtl/conv_sequencer.sv
// Walks one conv layer's loop nest, issues buffer reads and aligns accumulate/write
// strobes to the MAC pipeline via a tag shift register.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned AW       = DefAw,
  parameter int unsigned CW       = DefCw,
  parameter int unsigned PIPE_LAT = DefPipeLat
) (
  input  logic            clk,
  input  logic            rst_n,
  conv_sequencer_if.slave bus
);

  conv_state_e state_q, state_d;

  logic [CW-1:0] cfg_m_q, cfg_r_q, cfg_c_q, cfg_nw_q;
  logic [3:0]    cfg_k_q;

  logic accept, cfg_zero, issue, ctr_last, pipe_busy, wr_fire;

  logic [NumLevels-1:0][CW-1:0] lim, cnt;
  logic [NumLevels-1:0]         lvl_last;

  conv_tag_t pipe_q [PIPE_LAT];
  conv_tag_t tag_in, tag_out;

  logic          out_en_q;
  logic [7:0]    out_we_q;
  logic [AW-1:0] out_addr_q;

  logic [AW-1:0] m_a, r_a, c_a, nw_a, i_a, j_a;
  logic [AW-1:0] r_cfg, c_cfg, nw_cfg, k_a, taps, rows_p, cols_p;
  logic [AW-1:0] w_calc, ifm_calc, out_calc;

  assign accept   = (state_q == StIdle) & bus.start;
  assign cfg_zero = (bus.cfg_m == '0) | (bus.cfg_r == '0) | (bus.cfg_c == '0) |
                    (bus.cfg_nw == '0) | (bus.cfg_k == 4'd0);
  assign issue    = (state_q == StRun);
  assign ctr_last = &lvl_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = cfg_zero ? StDone : StRun;
      StRun:   if (ctr_last) state_d = StDrain;
      StDrain: if (!pipe_busy && out_en_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_m_q  <= '0;
      cfg_r_q  <= '0;
      cfg_c_q  <= '0;
      cfg_nw_q <= '0;
      cfg_k_q  <= '0;
    end else if (accept) begin
      cfg_m_q  <= bus.cfg_m;
      cfg_r_q  <= bus.cfg_r;
      cfg_c_q  <= bus.cfg_c;
      cfg_nw_q <= bus.cfg_nw;
      cfg_k_q  <= bus.cfg_k;
    end
  end

  always_comb begin
    lim       = '0;
    lim[LvlM]  = cfg_m_q;
    lim[LvlR]  = cfg_r_q;
    lim[LvlC]  = cfg_c_q;
    lim[LvlNw] = cfg_nw_q;
    lim[LvlI]  = CW'(cfg_k_q);
    lim[LvlJ]  = CW'(cfg_k_q);
  end

  conv_loop_ctr #(
    .Levels (NumLevels),
    .W      (CW)
  ) u_loop_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (accept),
    .adv_i      (issue),
    .lim_i      (lim),
    .cnt_o      (cnt),
    .lvl_last_o (lvl_last)
  );

  // Address arithmetic, all modulo 2^AW.
  always_comb begin
    m_a      = AW'(cnt[LvlM]);
    r_a      = AW'(cnt[LvlR]);
    c_a      = AW'(cnt[LvlC]);
    nw_a     = AW'(cnt[LvlNw]);
    i_a      = AW'(cnt[LvlI]);
    j_a      = AW'(cnt[LvlJ]);
    r_cfg    = AW'(cfg_r_q);
    c_cfg    = AW'(cfg_c_q);
    nw_cfg   = AW'(cfg_nw_q);
    k_a      = AW'(cfg_k_q);
    taps     = nw_cfg * k_a * k_a;
    rows_p   = r_cfg + k_a - AW'(1);
    cols_p   = c_cfg + k_a - AW'(1);
    w_calc   = m_a * taps + (nw_a * k_a + i_a) * k_a + j_a;
    ifm_calc = (nw_a * rows_p + r_a + i_a) * cols_p + c_a + j_a;
    out_calc = (m_a >> 2) * r_cfg * c_cfg + r_a * c_cfg + c_a;
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.first = issue & (cnt[LvlNw] == '0) & (cnt[LvlI] == '0) & (cnt[LvlJ] == '0);
    tag_in.last  = issue & lvl_last[LvlNw] & lvl_last[LvlI] & lvl_last[LvlJ];
    tag_in.addr  = TagAddrW'(out_calc);
    tag_in.lane  = cnt[LvlM][1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < PIPE_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned k = 0; k < PIPE_LAT; k++) begin
      pipe_busy = pipe_busy | pipe_q[k].valid;
    end
  end

  assign tag_out = pipe_q[PIPE_LAT-1];
  assign wr_fire = tag_out.valid & tag_out.last;

  // Write lags the last tap by one cycle so the accumulator has registered the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q   <= 1'b0;
      out_we_q   <= '0;
      out_addr_q <= '0;
    end else begin
      out_en_q   <= wr_fire;
      out_we_q   <= wr_fire ? lane_mask(tag_out.lane) : '0;
      out_addr_q <= wr_fire ? AW'(tag_out.addr) : '0;
    end
  end

  always_comb begin
    bus.busy      = (state_q == StRun) | (state_q == StDrain);
    bus.done      = (state_q == StDone);
    bus.ifm_en    = issue;
    bus.w_en      = issue;
    bus.ifm_addr  = issue ? ifm_calc : '0;
    bus.w_addr    = issue ? w_calc : '0;
    bus.acc_en    = tag_out.valid;
    bus.acc_clear = tag_out.valid & tag_out.first;
    bus.out_en    = out_en_q;
    bus.out_we    = out_we_q;
    bus.out_addr  = out_addr_q;
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: per-cycle output logs checked against
// hand-computed cycle numbers, addresses and masks.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  conv_sequencer_if #(.AW(16), .CW(8)) bus ();

  conv_sequencer #(
    .AW       (16),
    .CW       (8),
    .PIPE_LAT (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ifm_log   [512];
  logic [15:0] w_log     [512];
  logic [15:0] oaddr_log [512];
  logic [7:0]  we_log    [512];
  logic        en_log    [512];
  logic        acc_log   [512];
  logic        clr_log   [512];
  logic        oen_log   [512];
  logic        busy_log  [512];

  int n_issue, n_acc, n_clr, n_wr, n_skew, done_cyc, n_done_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start at cycle 0, log every cycle until done (bounded), end back in IDLE.
  task automatic run_layer(input int m, input int r, input int c, input int nw, input int k,
                           input int restart_at);
    int cyc;
    for (int i = 0; i < 512; i++) begin
      ifm_log[i] = '0; w_log[i] = '0; oaddr_log[i] = '0; we_log[i] = '0;
      en_log[i] = 1'b0; acc_log[i] = 1'b0; clr_log[i] = 1'b0; oen_log[i] = 1'b0;
      busy_log[i] = 1'b0;
    end
    n_issue = 0; n_acc = 0; n_clr = 0; n_wr = 0; n_skew = 0; done_cyc = -1;
    bus.cfg_m  = 8'(m);
    bus.cfg_r  = 8'(r);
    bus.cfg_c  = 8'(c);
    bus.cfg_nw = 8'(nw);
    bus.cfg_k  = 4'(k);
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      ifm_log[cyc]   = bus.ifm_addr;
      w_log[cyc]     = bus.w_addr;
      oaddr_log[cyc] = bus.out_addr;
      we_log[cyc]    = bus.out_we;
      en_log[cyc]    = bus.ifm_en;
      acc_log[cyc]   = bus.acc_en;
      clr_log[cyc]   = bus.acc_clear;
      oen_log[cyc]   = bus.out_en;
      busy_log[cyc]  = bus.busy;
      n_issue += int'(bus.ifm_en);
      n_acc   += int'(bus.acc_en);
      n_clr   += int'(bus.acc_clear);
      n_wr    += int'(bus.out_en);
      if (bus.ifm_en !== bus.w_en) n_skew++;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      bus.start = (cyc == restart_at);
      step();
      cyc++;
    end
    bus.start = 1'b0;
    chk("layer_done_seen", done_cyc >= 0, 1);
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.cfg_m  = '0;
    bus.cfg_r  = '0;
    bus.cfg_c  = '0;
    bus.cfg_nw = '0;
    bus.cfg_k  = '0;
    #2;
    chk("rst_busy_done", {bus.busy, bus.done}, 0);
    chk("rst_strobes", {bus.ifm_en, bus.w_en, bus.acc_en, bus.acc_clear, bus.out_en}, 0);
    chk("rst_rd_addr", {bus.ifm_addr, bus.w_addr}, 0);
    chk("rst_wr", {bus.out_we, bus.out_addr}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single tap, single neuron.
    run_layer(1, 1, 1, 1, 1, -1);
    chk("a_issue1_en", en_log[1], 1);
    chk("a_issue1_addr", {ifm_log[1], w_log[1]}, 0);
    chk("a_acc_c3", {acc_log[3], clr_log[3]}, 2'b11);
    chk("a_acc_c2", acc_log[2], 0);
    chk("a_wr_c4", {oen_log[4], we_log[4], oaddr_log[4]}, {1'b1, 8'hC0, 16'h0});
    chk("a_done_cyc", done_cyc, 5);
    chk("a_issues", n_issue, 1);

    // M=2, R=C=2, NW=2, K=3: T=18, 144 issues.
    run_layer(2, 2, 2, 2, 3, -1);
    chk("b_issues", n_issue, 144);
    chk("b_first_last_issue", {en_log[1], en_log[144], en_log[145]}, 3'b110);
    chk("b_done_cyc", done_cyc, 148);
    chk("b_writes", n_wr, 8);
    chk("b_acc_count", n_acc, 144);
    chk("b_clr_count", n_clr, 8);
    chk("b_en_skew", n_skew, 0);
    chk("b_n4_first_w", w_log[73], 18);
    chk("b_tap_ifm", ifm_log[72], 31);
    chk("b_tap_w", w_log[72], 17);
    chk("b_final_w", w_log[144], 35);
    chk("b_overlap", {oen_log[75], clr_log[75], acc_log[75]}, 3'b111);
    chk("b_overlap_wr", {we_log[75], oaddr_log[75]}, {8'hC0, 16'd3});
    for (int n = 0; n < 4; n++) begin
      chk("b_m1_wr", {oen_log[93 + 18 * n], we_log[93 + 18 * n], oaddr_log[93 + 18 * n]},
          {1'b1, 8'h30, 16'(n)});
    end
    chk("b_busy_edges", {busy_log[1], busy_log[147], busy_log[148]}, 3'b110);

    // M=5, R=C=1: lane wraps into the next output word.
    run_layer(5, 1, 1, 1, 1, -1);
    chk("c_m3_wr", {oen_log[7], we_log[7], oaddr_log[7]}, {1'b1, 8'h03, 16'd0});
    chk("c_m4_wr", {oen_log[8], we_log[8], oaddr_log[8]}, {1'b1, 8'hC0, 16'd1});
    chk("c_done_cyc", done_cyc, 9);

    // K=0: immediate done, no activity.
    run_layer(2, 2, 2, 2, 0, -1);
    chk("d_done_cyc", done_cyc, 1);
    chk("d_no_activity", {n_issue[7:0], n_acc[7:0], n_wr[7:0]}, 0);
    chk("d_no_busy", busy_log[1], 0);

    // Start pulsed mid-layer is ignored.
    run_layer(2, 2, 2, 2, 3, 40);
    chk("e_issues", n_issue, 144);
    chk("e_done_cyc", done_cyc, 148);
    chk("e_writes", n_wr, 8);

    // Abort at issue 50.
    bus.cfg_m  = 8'd2;
    bus.cfg_r  = 8'd2;
    bus.cfg_c  = 8'd2;
    bus.cfg_nw = 8'd2;
    bus.cfg_k  = 4'd3;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 50; i++) step();
    chk("f_issue50", {bus.ifm_en, bus.busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("f_abort_ctl", {bus.busy, bus.done, bus.ifm_en, bus.w_en, bus.acc_en, bus.acc_clear,
                        bus.out_en}, 0);
    chk("f_abort_rd", {bus.ifm_addr, bus.w_addr}, 0);
    chk("f_abort_wr", {bus.out_we, bus.out_addr}, 0);
    n_done_abort = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_done_abort += int'(bus.done) + int'(bus.out_en);
    end
    chk("f_no_done", n_done_abort, 0);
    rst_n = 1'b1;
    step();
    run_layer(2, 2, 2, 2, 3, -1);
    chk("f_clean_issues", n_issue, 144);
    chk("f_clean_done", done_cyc, 148);
    chk("f_clean_writes", n_wr, 8);
    chk("f_clean_first_w", {ifm_log[1], w_log[1]}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
